quad_decoder: RTL and testbench
===============================

QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 15, meaning consecutive stable cycles required before a filtered input changes; legal range 1..255.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port enc_a  input  1  raw quadrature channel A, asynchronous to clk.
REQ-005 SHALL have port enc_b  input  1  raw quadrature channel B, asynchronous to clk.
REQ-006 SHALL have port encoder_value  output  2  signed position count, modulo 4; feeds paddle encoder_value.
REQ-007 SHALL have port step_up  output  1  one-cycle pulse on each +1 step.
REQ-008 SHALL have port step_dn  output  1  one-cycle pulse on each -1 step.
REQ-009 SHALL have port err  output  1  one-cycle pulse on an illegal transition (both channels change in the same decode cycle).

Function
REQ-010 SHALL pass each of enc_a and enc_b through a 2-flop synchronizer (a_s, b_s).
REQ-011 SHALL keep filtered bits a_f, b_f, each with an 8-bit stability counter; counter clears whenever sync equals filtered.
REQ-012 SHALL increment a channel's counter each cycle its sync bit differs from its filtered bit; when the counter equals DEBOUNCE_CYCLES-1 and the bits still differ, filtered <= sync and counter <= 0.
REQ-013 SHALL keep prev = {a_f, b_f} of the previous cycle; decode compares prev against the current {a_f, b_f} every cycle.
REQ-014 SHALL treat sequence 00->01->11->10->00 as +1 steps and the reverse as -1 steps.
REQ-015 SHALL, on a +1 step, add 1 to encoder_value (2-bit wrap: 01+1=10, i.e. 1 -> -2) and pulse step_up for exactly one cycle.
REQ-016 SHALL, on a -1 step, subtract 1 from encoder_value (wrap: 10-1=01) and pulse step_dn for exactly one cycle.
REQ-017 SHALL, on a 2-bit change (00<->11, 01<->10), leave encoder_value unchanged, pulse err, and still update prev.
REQ-018 SHALL, when prev equals current, hold encoder_value and drive step_up, step_dn, err low.
REQ-019 SHALL never assert more than one of step_up, step_dn, err in the same cycle.
REQ-020 SHALL register all outputs; encoder_value and pulses change on the same edge.
REQ-021 SHALL give latency from a stable input change to encoder_value update of 2 (sync) + DEBOUNCE_CYCLES (filter) + 1 (decode) cycles.
REQ-022 SHALL discard a glitch on a channel shorter than DEBOUNCE_CYCLES cycles with no output effect.

Reset
REQ-023 SHALL, while reset is high, clear encoder_value, step_up, step_dn, err, synchronizers, filters, counters, prev, and a 2-bit settle counter to 0.
REQ-024 SHALL, for the first 3 cycles after reset deasserts (settle counter 0..2), load filtered bits directly from sync bits, load prev from filtered bits, and suppress all counting and pulses.
REQ-025 SHALL begin normal decoding once the settle counter saturates at 3; the counter holds until the next reset.
REQ-026 SHALL abandon any in-progress debounce or pending step when reset asserts mid-operation; no pulse is emitted for it.

Configuration
REQ-027 SHALL, with macro QUAD_DECODER_DEBOUNCE_EN defined, implement the debounce filters of REQ-011/012 exactly as specified.
REQ-028 SHALL, without QUAD_DECODER_DEBOUNCE_EN, drop the counters and register filtered <= sync every cycle, giving latency 2 + 1 + 1 = 4 cycles and no glitch rejection; the DEBOUNCE_CYCLES parameter is then ignored.

Verification
REQ-029 SHALL cover: reset, then drive A/B through 00,01,11,10,00 each held 40 cycles (DEBOUNCE_CYCLES=15) -> encoder_value 1,-2,-1,0 with 4 step_up pulses, no step_dn/err.
REQ-030 SHALL cover: reverse sequence 00,10,11,01,00 -> encoder_value -1,-2,1,0 with 4 step_dn pulses.
REQ-031 SHALL cover: 10-cycle pulse on A with debounce enabled -> no output change; same stimulus without the macro -> +1 then -1 step.
REQ-032 SHALL cover: A and B toggled 00->11 on the same edge -> one err pulse, encoder_value unchanged, next legal step counted from 11.
REQ-033 SHALL cover: reset with A=B=1 held -> no step or err pulse during or after settle; encoder_value stays 0.
REQ-034 SHALL cover: stable change on A, measure cycles to encoder_value update -> exactly 18 with debounce (DEBOUNCE_CYCLES=15), 4 without.

Source files
------------

// File: rtl/quad_decoder_if.sv
// Quadrature encoder pins plus decoded position/pulse outputs of quad_decoder.
// The master drives the raw encoder channels; the slave (decoder) drives the results.
interface quad_decoder_if;
  logic       enc_a;
  logic       enc_b;
  logic [1:0] encoder_value;
  logic       step_up;
  logic       step_dn;
  logic       err;

  modport master (
    output enc_a, enc_b,
    input  encoder_value, step_up, step_dn, err
  );

  modport slave (
    input  enc_a, enc_b,
    output encoder_value, step_up, step_dn, err
  );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature decoder: 2-flop synchronizers, per-channel filter, Gray-step decode to a 2-bit count.
// Define QUAD_DECODER_DEBOUNCE_EN to enable the DEBOUNCE_CYCLES stability filters.
module quad_decoder #(
  parameter int DEBOUNCE_CYCLES = 15
) (
  input  logic          clk,
  input  logic          reset,
  quad_decoder_if.slave bus
);
  // Bit 1 carries channel A and bit 0 channel B, so the pair reads as the {a,b} code.
  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync_q, sync_d;
  logic [1:0] filt_q, filt_d;
  logic [1:0] prev_q, prev_d;
  logic [1:0] settle_q, settle_d;
  logic [1:0] value_q, value_d;
  logic       up_q, up_d;
  logic       dn_q, dn_d;
  logic       err_q, err_d;
  logic [1:0] delta;
  logic       settled;

  assign settled = (settle_q == 2'd3);

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
`ifdef QUAD_DECODER_DEBOUNCE_EN
    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       f_d;

    always_comb begin
      f_d   = filt_q[gi];
      cnt_d = '0;
      if (!settled) begin
        f_d = sync_q[gi];
      end else if (sync_q[gi] != filt_q[gi]) begin
        if (cnt_q == DEB_LAST) begin
          f_d = sync_q[gi];
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign filt_d[gi] = f_d;
`else
    assign filt_d[gi] = sync_q[gi];
`endif
  end

  // Position of an {a,b} code along the forward sequence 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  always_comb begin
    sync1_d  = {bus.enc_a, bus.enc_b};
    sync_d   = sync1_q;
    settle_d = settled ? settle_q : settle_q + 2'd1;
    // While settling, prev tracks the filter's next value so the first live decode sees no edge.
    prev_d   = settled ? filt_q : filt_d;
    delta    = gray_pos(filt_q) - gray_pos(prev_q);
    value_d  = value_q;
    up_d     = 1'b0;
    dn_d     = 1'b0;
    err_d    = 1'b0;
    if (settled) begin
      case (delta)
        2'd1: begin
          value_d = value_q + 2'd1;
          up_d    = 1'b1;
        end
        2'd3: begin
          value_d = value_q - 2'd1;
          dn_d    = 1'b1;
        end
        2'd2:    err_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync_q   <= '0;
      filt_q   <= '0;
      prev_q   <= '0;
      settle_q <= '0;
      value_q  <= '0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync_q   <= sync_d;
      filt_q   <= filt_d;
      prev_q   <= prev_d;
      settle_q <= settle_d;
      value_q  <= value_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      err_q    <= err_d;
    end
  end

  assign bus.encoder_value = value_q;
  assign bus.step_up       = up_q;
  assign bus.step_dn       = dn_q;
  assign bus.err           = err_q;
endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed sequences plus random steps against a position model.
// Expected latency follows QUAD_DECODER_DEBOUNCE_EN (2 + DEB + 1 with filters, 4 without).
module tb_quad_decoder;
  localparam int DEB = 15;
`ifdef QUAD_DECODER_DEBOUNCE_EN
  localparam int LAT    = 3 + DEB;
  localparam bit DEB_ON = 1'b1;
`else
  localparam int LAT    = 4;
  localparam bit DEB_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  quad_decoder_if bus ();

  quad_decoder #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: the code last driven and the expected count (0..3, i.e. modulo 4).
  logic [1:0] cur_ab;
  int         exp_val;
  int         pos_of [4] = '{0, 1, 3, 2};
  logic [1:0] ab_of  [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int val, input bit up, input bit dn, input bit er);
    check({tag, ".value"}, {6'd0, bus.encoder_value}, 8'(val));
    check({tag, ".step_up"}, {7'd0, bus.step_up}, {7'd0, up});
    check({tag, ".step_dn"}, {7'd0, bus.step_dn}, {7'd0, dn});
    check({tag, ".err"}, {7'd0, bus.err}, {7'd0, er});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] ab);
    bus.enc_a = ab[1];
    bus.enc_b = ab[0];
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      tick();
      check_out(tag, exp_val, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Move the encoder to new_ab and hold it; the decoded step appears exactly LAT edges later.
  task automatic apply_ab(input logic [1:0] new_ab, input int hold, input string tag);
    int d, new_val;
    d       = (pos_of[new_ab] - pos_of[cur_ab] + 4) % 4;
    new_val = (d == 1) ? (exp_val + 1) % 4 : (d == 3) ? (exp_val + 3) % 4 : exp_val;
    drive(new_ab);
    for (int k = 1; k <= hold; k++) begin
      tick();
      if (k < LAT)       check_out(tag, exp_val, 1'b0, 1'b0, 1'b0);
      else if (k == LAT) check_out(tag, new_val, d == 1, d == 3, d == 2);
      else               check_out(tag, new_val, 1'b0, 1'b0, 1'b0);
    end
    $display("step %s: ab %b -> %b, value %0d", tag, cur_ab, new_ab, new_val);
    cur_ab  = new_ab;
    exp_val = new_val;
  endtask

  // Flip channel A for g cycles then return; rejected entirely when debounce is on and g < DEB.
  task automatic glitch_a(input int g, input string tag);
    logic [1:0] mid;
    int         d, mid_val, vis;
    bit         rejected;
    mid      = cur_ab ^ 2'b10;
    d        = (pos_of[mid] - pos_of[cur_ab] + 4) % 4;
    mid_val  = (d == 1) ? (exp_val + 1) % 4 : (exp_val + 3) % 4;
    rejected = DEB_ON && (g < DEB);
    drive(mid);
    for (int k = 1; k <= g + LAT + 5; k++) begin
      tick();
      if (k == g) drive(cur_ab);
      if (rejected)          check_out(tag, exp_val, 1'b0, 1'b0, 1'b0);
      else if (k == LAT)     check_out(tag, mid_val, d == 1, d == 3, 1'b0);
      else if (k == g + LAT) check_out(tag, exp_val, d == 3, d == 1, 1'b0);
      else if (k > LAT && k < g + LAT) check_out(tag, mid_val, 1'b0, 1'b0, 1'b0);
      else                   check_out(tag, exp_val, 1'b0, 1'b0, 1'b0);
    end
    $display("glitch %s: %0d cycles on A, rejected=%0d", tag, g, rejected);
  endtask

  initial begin
    int n;
    logic [1:0] nxt;

    drive(2'b00);
    reset = 1'b1;
    cur_ab  = 2'b00;
    exp_val = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out("reset", 0, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    idle(8, "post_reset");

    // Forward sequence: 1, -2, -1, 0 with four step_up pulses.
    apply_ab(2'b01, 40, "fwd1");
    apply_ab(2'b11, 40, "fwd2");
    apply_ab(2'b10, 40, "fwd3");
    apply_ab(2'b00, 40, "fwd4");

    // Reverse sequence: -1, -2, 1, 0 with four step_dn pulses.
    apply_ab(2'b10, 40, "rev1");
    apply_ab(2'b11, 40, "rev2");
    apply_ab(2'b01, 40, "rev3");
    apply_ab(2'b00, 40, "rev4");

    // Both channels at once, then a legal step counted from 11.
    apply_ab(2'b11, 40, "illegal");
    apply_ab(2'b10, 40, "after_err");

    apply_ab(2'b00, 40, "to00");
    apply_ab(2'b01, 40, "to01");
    glitch_a(10, "glitch10");
    glitch_a(1, "glitch1");

    // Latency from a stable A change (01 -> 11, a +1 step) to the count update.
    drive(2'b11);
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      if (bus.encoder_value !== 2'(exp_val)) break;
    end
    check("latency", 8'(n), 8'(LAT));
    exp_val = (exp_val + 1) % 4;
    check_out("latency_step", exp_val, 1'b1, 1'b0, 1'b0);
    $display("latency: %0d cycles", n);
    cur_ab = 2'b11;
    idle(10, "latency_hold");

    for (int i = 0; i < 40; i++) begin
      nxt = ab_of[$urandom_range(0, 3)];
      apply_ab(nxt, LAT + 1 + int'($urandom_range(0, 6)), $sformatf("rand%0d", i));
    end

    // Reset mid-step: the pending change must never surface as a pulse.
    nxt = cur_ab ^ 2'b01;
    drive(nxt);
    for (int k = 1; k <= LAT - 2; k++) begin
      tick();
      check_out("midop_pending", exp_val, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b1;
    exp_val = 0;
    idle(2, "midop_reset");
    reset = 1'b0;
    cur_ab = nxt;
    idle(30, "midop_after");
    $display("reset mid-step: ab %b, value 0", nxt);

    // Reset with both channels high: settling must not see a spurious 00 -> 11 edge.
    drive(2'b11);
    reset = 1'b1;
    idle(3, "rst11_during");
    reset = 1'b0;
    cur_ab = 2'b11;
    idle(30, "rst11_after");
    $display("reset with ab=11: value 0, no pulses");
    apply_ab(2'b10, 40, "rst11_step");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
